store_outstanding_tracker: RTL

- Sits between the store unit and the AXI write-address/write-response channels of the write-back data-cache path.
- Gates each store request onto AW and counts outstanding writes against a limit.
- Serialises stores to non-idempotent regions.
- Drains all outstanding writes for fences.
- Classifies addresses with the non-idempotent rules carried in the core configuration struct.

---
 rtl/store_outstanding_tracker_pkg.sv | 32 +++
 rtl/store_outstanding_tracker_region_check.sv | 9 +
 rtl/store_outstanding_tracker.sv | 77 +++++++
 3 files changed

// File: rtl/store_outstanding_tracker_pkg.sv
// store_outstanding_tracker_pkg: core config type, tracker FSM states and the shared non-idempotent classifier
package store_outstanding_tracker_pkg;
   localparam int unsigned MaxRules = 4;

   typedef struct packed {
      int unsigned               AxiAddrWidth;
      int unsigned               MaxOutstandingStores;
      int unsigned               NrNonIdempotentRules;
      logic [MaxRules-1:0][63:0] NonIdempotentAddrBase;
      logic [MaxRules-1:0][63:0] NonIdempotentLength;
   } cva6_cfg_t;

   localparam cva6_cfg_t DefaultCfg = '{
      AxiAddrWidth:          64,
      MaxOutstandingStores:  7,
      NrNonIdempotentRules:  1,
      NonIdempotentAddrBase: {64'h0, 64'h0, 64'h0, 64'h1000_0000},
      NonIdempotentLength:   {64'h0, 64'h0, 64'h0, 64'h1000}
   };

   typedef enum logic [1:0] {IDLE, NI_WAIT, DRAIN, DONE} trk_state_e;

   // Region end is formed one bit wider so a rule touching the top of the map cannot wrap
   function automatic logic is_non_idempotent(cva6_cfg_t cfg, logic [63:0] addr);
      logic hit;
      hit = 1'b0;
      for (int unsigned i = 0; i < MaxRules; i++)
         hit |= i < cfg.NrNonIdempotentRules && addr >= cfg.NonIdempotentAddrBase[i] &&
                {1'b0, addr} < {1'b0, cfg.NonIdempotentAddrBase[i]} + {1'b0, cfg.NonIdempotentLength[i]};
      return hit;
   endfunction
endpackage

// File: rtl/store_outstanding_tracker_region_check.sv
// store_region_check: combinational match of a write address against the non-idempotent rules
module store_region_check import store_outstanding_tracker_pkg::*; #(
   parameter cva6_cfg_t CVA6Cfg = DefaultCfg
) (
   input  logic [CVA6Cfg.AxiAddrWidth-1:0] addr,
   output logic                            ni
);
   assign ni = is_non_idempotent(CVA6Cfg, 64'(addr));
endmodule

// File: rtl/store_outstanding_tracker.sv
// store_outstanding_tracker: gates stores onto AW, counts outstanding writes, serialises NI stores, drains for fences
module store_outstanding_tracker import store_outstanding_tracker_pkg::*; #(
   parameter cva6_cfg_t   CVA6Cfg        = DefaultCfg,
   parameter int unsigned MaxOutstanding = CVA6Cfg.MaxOutstandingStores,
   parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            req_valid_i,
   input  logic [CVA6Cfg.AxiAddrWidth-1:0] req_addr_i,
   output logic                            req_ready_o,
   output logic                            aw_valid_o,
   input  logic                            aw_ready_i,
   input  logic                            b_valid_i,
   input  logic [1:0]                      b_resp_i,
   output logic                            b_ready_o,
   input  logic                            fence_i,
   output logic                            fence_done_o,
   output logic [CntWidth-1:0]             outstanding_o,
   output logic                            idle_o,
   output logic                            bus_err_o,
   input  logic                            clear_err_i
);
   trk_state_e          state_q, state_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                ni, allow, aw_hs, b_hs, err_set, err_q;
   logic                unused_resp;

   store_region_check #(.CVA6Cfg(CVA6Cfg)) i_region (.addr(req_addr_i), .ni(ni));

   // A fence in the same cycle wins over a store; NI stores only go out with nothing in flight
   assign allow         = state_q == IDLE && !fence_i && cnt_q < CntWidth'(MaxOutstanding) && (!ni || cnt_q == '0);
   assign aw_valid_o    = req_valid_i && allow;
   assign req_ready_o   = aw_ready_i && allow;
   assign aw_hs         = aw_valid_o && aw_ready_i;
   assign b_ready_o     = 1'b1;
   assign b_hs          = b_valid_i && b_ready_o;
   assign err_set       = b_hs && (b_resp_i[1] || (cnt_q == '0 && !aw_hs));
   assign unused_resp   = b_resp_i[0];
   assign outstanding_o = cnt_q;
   assign idle_o        = cnt_q == '0 && state_q == IDLE;
   assign fence_done_o  = state_q == DONE;
   assign bus_err_o     = err_q;

   // Counter update; a stray B with nothing outstanding leaves the count at zero
   always_comb
      cnt_d = (aw_hs && !b_hs) ? cnt_q + CntWidth'(1) :
              (b_hs && !aw_hs && cnt_q != '0) ? cnt_q - CntWidth'(1) : cnt_q;

   // Next-state logic; DRAIN completes in the cycle the last response is counted
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = fence_i ? DRAIN : (aw_hs && ni) ? NI_WAIT : IDLE;
         NI_WAIT: state_d = fence_i ? DRAIN : (b_hs && cnt_q == CntWidth'(1)) ? IDLE : NI_WAIT;
         DRAIN:   state_d = cnt_d == '0 ? DONE : DRAIN;
         default: state_d = IDLE;
      endcase
   end

   // State, count and sticky error registers; a new error outranks a clear
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_set || (err_q && !clear_err_i);
      end
   end

   // The issue gate must never let the count exceed the limit
   always_ff @(posedge clk_i)
      if (!rst_i) assert (cnt_q <= CntWidth'(MaxOutstanding));
endmodule
